ifu_fetch_queue: RTL and testbench
==================================

IFU_FETCH_QUEUE -- requirements
Module: ifu_fetch_queue

Interface
REQ-001 The block SHALL have parameter INSTR_PER_FETCH, default 4, meaning enqueue lanes per cycle.
REQ-002 The block SHALL have parameter DEQ_WIDTH, default 4, meaning dequeue lanes per cycle.
REQ-003 The block SHALL have parameter DEPTH, default 8, meaning entry count; power of two and >= INSTR_PER_FETCH.
REQ-004 The block SHALL have parameter XLEN, default 32, meaning PC width.
REQ-005 The block SHALL have parameter ILEN, default 32, meaning instruction width.
REQ-006 The block SHALL have parameter BYPASS_EN, default 1, meaning empty-queue same-cycle pass-through is enabled.
REQ-007 The block SHALL have port clk_i, input, 1, meaning the single clock.
REQ-008 The block SHALL have port rst_i, input, 1, meaning reset; one clock; reset is synchronous and active-high.
REQ-009 The block SHALL have port flush_i, input, 1, meaning discard all contents.
REQ-010 The block SHALL have port enq_valid_i, input, 1, meaning a fetch bundle is offered.
REQ-011 The block SHALL have port enq_mask_i, input, INSTR_PER_FETCH, meaning per-lane valid bits (any pattern).
REQ-012 The block SHALL have port enq_pc_i, input, INSTR_PER_FETCH*XLEN, meaning lane PCs with lane 0 in the LSBs.
REQ-013 The block SHALL have port enq_instr_i, input, INSTR_PER_FETCH*ILEN, meaning lane instructions.
REQ-014 The block SHALL have port enq_ready_o, output, 1, meaning a whole bundle can be accepted.
REQ-015 The block SHALL have port deq_valid_o, output, DEQ_WIDTH, meaning output lane valid (thermometer from lane 0).
REQ-016 The block SHALL have port deq_pc_o, output, DEQ_WIDTH*XLEN, meaning output PCs.
REQ-017 The block SHALL have port deq_instr_o, output, DEQ_WIDTH*ILEN, meaning output instructions.
REQ-018 The block SHALL have port deq_cnt_i, input, $clog2(DEQ_WIDTH+1), meaning lanes consumed this cycle.
REQ-019 The block SHALL have port count_o, output, $clog2(DEPTH+1), meaning registered occupancy.

Function
REQ-020 The block SHALL be a circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a registered count.
REQ-021 The block SHALL drive enq_ready_o = (DEPTH - count) >= INSTR_PER_FETCH, a function of registered count only and independent of deq_cnt_i.
REQ-022 The block SHALL define fire = enq_valid_i & enq_ready_o & ~flush_i and n_enq = popcount(enq_mask_i) when fire, else 0.
REQ-023 On fire, the block SHALL compact the masked lanes in ascending lane order into slots wr_ptr, wr_ptr+1, ... (mod DEPTH) and advance wr_ptr by n_enq.
REQ-024 When fire with enq_mask_i = 0, the block SHALL accept the bundle as a no-op with no state change.
REQ-025 When count > 0, the block SHALL set deq_valid_o[k] = 1 iff k < min(count, DEQ_WIDTH), with lane k driven from slot rd_ptr+k; entries written in cycle N SHALL first be visible in N+1.
REQ-026 When count = 0, BYPASS_EN = 1 and fire, the block SHALL present the compacted incoming lanes combinationally in the same cycle, with valid for k < min(n_enq, DEQ_WIDTH).
REQ-027 When count = 0 and there is no bypass, the block SHALL hold deq_valid_o at 0.
REQ-028 The block SHALL advance rd_ptr by deq_cnt_i; entries are always written to storage, so bypassed-and-consumed lanes SHALL occupy no space after the cycle.
REQ-029 The block SHALL update count_next = count + n_enq - deq_cnt_i, and simultaneous enqueue and dequeue SHALL be legal.
REQ-030 deq_cnt_i SHALL NOT exceed popcount(deq_valid_o); the block SHALL carry a simulation assertion on this, with behaviour undefined on violation.
REQ-031 When flush_i = 1, the block SHALL force deq_valid_o to 0, ignore enqueue and deq_cnt_i, and set rd_ptr, wr_ptr and count to 0 next cycle.
REQ-032 The pc/instr output lanes with valid 0 SHALL be don't-care.
REQ-033 For full wrap-around, a bundle straddling slot DEPTH-1 SHALL continue at slot 0.

Reset
REQ-034 While rst_i = 1 at a clock edge, the block SHALL set rd_ptr, wr_ptr and count to 0; rst_i SHALL override flush_i and enqueue.
REQ-035 After reset, the block SHALL drive count_o = 0, deq_valid_o = 0 and enq_ready_o = 1; storage contents need not be reset.
REQ-036 Reset asserted mid-operation SHALL discard all entries, including any same-cycle enqueue.

Verification
REQ-037 Bypass scenario: with the queue empty, apply mask 4'b1111, PCs 0x100..0x10C and deq_cnt_i = 2 -> same cycle deq_valid_o = 4'b1111 and deq_pc_o[0] = 0x100; next cycle count_o = 2 and deq_pc_o[0] = 0x108.
REQ-038 Compaction scenario: apply mask 4'b1010 with PCs 0x200..0x20C and deq_cnt_i = 0 -> count_o = 2, with lanes 0/1 showing 0x204/0x20C.
REQ-039 Full scenario: enqueue two full bundles (DEPTH 8) with no dequeue -> count_o = 8 and enq_ready_o = 0; after deq_cnt_i = 4, count_o = 4 and enq_ready_o = 1.
REQ-040 Wrap scenario: run 20 cycles of full enqueue with deq_cnt_i = 4 and PCs incrementing by 4 -> output PCs strictly sequential with no loss or duplication across the slot 7->0 boundary.
REQ-041 Flush scenario: with count = 5, apply flush_i together with enq_valid_i and mask 4'b1111 -> deq_valid_o = 0 that cycle and count_o = 0 next cycle.
REQ-042 Parameter scenario: rerun the scenarios with BYPASS_EN = 0, DEQ_WIDTH = 2 and DEPTH = 16 -> empty-queue enqueue visible only one cycle later, and at most 2 lanes valid.

Source files
------------

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue: circular buffer taking up to INSTR_PER_FETCH masked
// lanes per cycle and presenting up to DEQ_WIDTH in-order lanes to decode.
module ifu_fetch_queue #(
  parameter int INSTR_PER_FETCH = 4,
  parameter int DEQ_WIDTH       = 4,
  parameter int DEPTH           = 8,
  parameter int XLEN            = 32,
  parameter int ILEN            = 32,
  parameter bit BYPASS_EN       = 1'b1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic                                 enq_valid_i,
  input  logic [INSTR_PER_FETCH-1:0]           enq_mask_i,
  input  logic [INSTR_PER_FETCH*XLEN-1:0]      enq_pc_i,
  input  logic [INSTR_PER_FETCH*ILEN-1:0]      enq_instr_i,
  output logic                                 enq_ready_o,
  output logic [DEQ_WIDTH-1:0]                 deq_valid_o,
  output logic [DEQ_WIDTH*XLEN-1:0]            deq_pc_o,
  output logic [DEQ_WIDTH*ILEN-1:0]            deq_instr_o,
  input  logic [$clog2(DEQ_WIDTH+1)-1:0]       deq_cnt_i,
  output logic [$clog2(DEPTH+1)-1:0]           count_o
);

  // Handshake: a bundle transfers in any cycle where enq_valid_i & enq_ready_o
  // & ~flush_i; enq_ready_o depends on registered occupancy only. On the
  // dequeue side deq_valid_o is a thermometer and the consumer returns how many
  // of the leading valid lanes it took via deq_cnt_i in the same cycle.

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int LW   = $clog2(INSTR_PER_FETCH + 1);
  localparam int CMPN = (INSTR_PER_FETCH > DEQ_WIDTH) ? INSTR_PER_FETCH : DEQ_WIDTH;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - INSTR_PER_FETCH);

  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [ILEN-1:0] instr_mem [DEPTH];

  logic            fire;
  logic [LW-1:0]   n_mask;
  logic [LW-1:0]   n_enq;
  logic [LW-1:0]   lane_pos  [INSTR_PER_FETCH];
  logic [XLEN-1:0] cmp_pc    [CMPN];
  logic [ILEN-1:0] cmp_instr [CMPN];

  assign enq_ready_o = (count <= READY_MAX);
  assign fire        = enq_valid_i & enq_ready_o & ~flush_i;
  assign count_o     = count;

  // lane_pos[i] is the number of valid lanes below lane i, i.e. the slot
  // offset from wr_ptr where lane i lands after compaction.
  always_comb begin
    logic [LW-1:0] acc;
    acc = '0;
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      lane_pos[i] = acc;
      acc = acc + LW'(enq_mask_i[i]);
    end
    n_mask = acc;
  end

  assign n_enq = fire ? n_mask : '0;

  always_comb begin
    for (int j = 0; j < CMPN; j++) begin
      cmp_pc[j]    = '0;
      cmp_instr[j] = '0;
      for (int i = 0; i < INSTR_PER_FETCH; i++) begin
        if (enq_mask_i[i] && (int'(lane_pos[i]) == j)) begin
          cmp_pc[j]    = enq_pc_i[i*XLEN +: XLEN];
          cmp_instr[j] = enq_instr_i[i*ILEN +: ILEN];
        end
      end
    end
  end

  // Storage is written on every accepted bundle, bypassed or not, so the
  // pointer arithmetic alone decides what remains occupied.
  always_ff @(posedge clk_i) begin
    if (fire) begin
      for (int i = 0; i < INSTR_PER_FETCH; i++) begin
        if (enq_mask_i[i]) begin
          pc_mem[wr_ptr + PW'(lane_pos[i])]    <= enq_pc_i[i*XLEN +: XLEN];
          instr_mem[wr_ptr + PW'(lane_pos[i])] <= enq_instr_i[i*ILEN +: ILEN];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_enq);
      rd_ptr <= rd_ptr + PW'(deq_cnt_i);
      count  <= count + CW'(n_enq) - CW'(deq_cnt_i);
    end
  end

  always_comb begin
    deq_valid_o = '0;
    deq_pc_o    = '0;
    deq_instr_o = '0;
    if (flush_i) begin
      deq_valid_o = '0;
    end else if (count != '0) begin
      for (int k = 0; k < DEQ_WIDTH; k++) begin
        deq_valid_o[k]               = (k < int'(count));
        deq_pc_o[k*XLEN +: XLEN]     = pc_mem[rd_ptr + PW'(k)];
        deq_instr_o[k*ILEN +: ILEN]  = instr_mem[rd_ptr + PW'(k)];
      end
    end else if (BYPASS_EN && fire) begin
      for (int k = 0; k < DEQ_WIDTH; k++) begin
        deq_valid_o[k]               = (k < int'(n_enq));
        deq_pc_o[k*XLEN +: XLEN]     = cmp_pc[k];
        deq_instr_o[k*ILEN +: ILEN]  = cmp_instr[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      deq_cnt_legal: assert ($countones(deq_valid_o) >= int'(deq_cnt_i));
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: a default instance checked by a streaming
// scoreboard plus directed checks, and a narrow no-bypass deep instance.
module tb_ifu_fetch_queue;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance A: defaults
  logic         a_flush, a_enq_valid, a_ready;
  logic [3:0]   a_mask, a_deq_valid, a_count;
  logic [127:0] a_pc, a_instr, a_deq_pc, a_deq_instr;
  logic [2:0]   a_deq_cnt;

  // instance B: no bypass, 2 dequeue lanes, 16 entries
  logic         b_flush, b_enq_valid, b_ready;
  logic [3:0]   b_mask;
  logic [127:0] b_pc, b_instr;
  logic [1:0]   b_deq_valid, b_deq_cnt;
  logic [63:0]  b_deq_pc, b_deq_instr;
  logic [4:0]   b_count;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_in_q[$];

  ifu_fetch_queue #(.INSTR_PER_FETCH(4), .DEQ_WIDTH(4), .DEPTH(8), .XLEN(32),
                    .ILEN(32), .BYPASS_EN(1'b1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .enq_valid_i(a_enq_valid),
    .enq_mask_i(a_mask), .enq_pc_i(a_pc), .enq_instr_i(a_instr),
    .enq_ready_o(a_ready), .deq_valid_o(a_deq_valid), .deq_pc_o(a_deq_pc),
    .deq_instr_o(a_deq_instr), .deq_cnt_i(a_deq_cnt), .count_o(a_count)
  );

  ifu_fetch_queue #(.INSTR_PER_FETCH(4), .DEQ_WIDTH(2), .DEPTH(16), .XLEN(32),
                    .ILEN(32), .BYPASS_EN(1'b0)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .enq_valid_i(b_enq_valid),
    .enq_mask_i(b_mask), .enq_pc_i(b_pc), .enq_instr_i(b_instr),
    .enq_ready_o(b_ready), .deq_valid_o(b_deq_valid), .deq_pc_o(b_deq_pc),
    .deq_instr_o(b_deq_instr), .deq_cnt_i(b_deq_cnt), .count_o(b_count)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0] ^ 16'h3c3c};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive instance A for one cycle; accepted lanes go to the scoreboard in
  // compacted order.
  task automatic a_set(input logic v, input logic [3:0] m, input logic [31:0] base,
                       input int deq, input logic fl);
    a_enq_valid = v;
    a_mask      = m;
    a_deq_cnt   = 3'(deq);
    a_flush     = fl;
    for (int i = 0; i < 4; i++) begin
      a_pc[i*32 +: 32]    = base + 32'(4 * i);
      a_instr[i*32 +: 32] = instr_of(base + 32'(4 * i));
    end
    if (fl) begin
      exp_pc_q.delete();
      exp_in_q.delete();
    end else if (v) begin
      for (int i = 0; i < 4; i++) begin
        if (m[i]) begin
          exp_pc_q.push_back(base + 32'(4 * i));
          exp_in_q.push_back(instr_of(base + 32'(4 * i)));
        end
      end
    end
  endtask

  task automatic b_set(input logic v, input logic [3:0] m, input logic [31:0] base,
                       input int deq);
    b_enq_valid = v;
    b_mask      = m;
    b_deq_cnt   = 2'(deq);
    b_flush     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_pc[i*32 +: 32]    = base + 32'(4 * i);
      b_instr[i*32 +: 32] = instr_of(base + 32'(4 * i));
    end
  endtask

  // Monitor for instance A: every presented lane must match the scoreboard
  // head in order; consumed lanes retire from it.
  always @(negedge clk) begin
    if (rst === 1'b0 && a_flush === 1'b0) begin
      for (int k = 0; k < 4; k++) begin
        if (a_deq_valid[k]) begin
          if (k < exp_pc_q.size()) begin
            chk("mon_pc", 64'(a_deq_pc[k*32 +: 32]), 64'(exp_pc_q[k]));
            chk("mon_instr", 64'(a_deq_instr[k*32 +: 32]), 64'(exp_in_q[k]));
          end else begin
            tests++;
            fails++;
            $display("FAIL mon_unexpected: lane %0d valid with pc 0x%0h, scoreboard holds %0d",
                     k, a_deq_pc[k*32 +: 32], exp_pc_q.size());
          end
        end
      end
      for (int k = 0; k < int'(a_deq_cnt); k++) begin
        if (exp_pc_q.size() > 0) begin
          void'(exp_pc_q.pop_front());
          void'(exp_in_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    a_set(0, 4'h0, 32'h0, 0, 0);
    b_set(0, 4'h0, 32'h0, 0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_count_a", 64'(a_count), 0);
    chk("rst_valid_a", 64'(a_deq_valid), 0);
    chk("rst_ready_a", 64'(a_ready), 1);
    chk("rst_count_b", 64'(b_count), 0);
    chk("rst_ready_b", 64'(b_ready), 1);

    // bypass into empty queue, consume two lanes the same cycle
    a_set(1, 4'hF, 32'h100, 2, 0); #1;
    chk("byp_valid", 64'(a_deq_valid), 4'hF);
    chk("byp_pc0", 64'(a_deq_pc[31:0]), 32'h100);
    step(); a_set(0, 4'h0, 32'h0, 2, 0); #1;
    chk("byp_count", 64'(a_count), 2);
    chk("byp_valid_next", 64'(a_deq_valid), 4'b0011);
    chk("byp_pc0_next", 64'(a_deq_pc[31:0]), 32'h108);
    step(); a_set(0, 4'h0, 32'h0, 0, 0); #1;
    chk("byp_drained", 64'(a_count), 0);
    chk("empty_valid", 64'(a_deq_valid), 0);

    // sparse mask compaction
    a_set(1, 4'b1010, 32'h200, 0, 0); #1;
    chk("cmp_byp_valid", 64'(a_deq_valid), 4'b0011);
    step(); a_set(0, 4'h0, 32'h0, 2, 0); #1;
    chk("cmp_count", 64'(a_count), 2);
    chk("cmp_lane0", 64'(a_deq_pc[31:0]), 32'h204);
    chk("cmp_lane1", 64'(a_deq_pc[63:32]), 32'h20c);

    // all-zero mask is an accepted no-op
    step(); a_set(1, 4'h0, 32'h280, 0, 0); #1;
    chk("nop_valid", 64'(a_deq_valid), 0);
    chk("nop_ready", 64'(a_ready), 1);
    step(); a_set(0, 4'h0, 32'h0, 0, 0); #1;
    chk("nop_count", 64'(a_count), 0);

    // fill to DEPTH, then free one bundle's worth
    a_set(1, 4'hF, 32'h300, 0, 0); step();
    a_set(1, 4'hF, 32'h310, 0, 0); #1;
    chk("full_mid_count", 64'(a_count), 4);
    chk("full_mid_ready", 64'(a_ready), 1);
    step(); a_set(0, 4'h0, 32'h0, 4, 0); #1;
    chk("full_count", 64'(a_count), 8);
    chk("full_ready", 64'(a_ready), 0);
    chk("full_valid", 64'(a_deq_valid), 4'hF);
    step(); a_set(0, 4'h0, 32'h0, 4, 0); #1;
    chk("half_count", 64'(a_count), 4);
    chk("half_ready", 64'(a_ready), 1);
    step(); a_set(0, 4'h0, 32'h0, 0, 0); #1;
    chk("full_drained", 64'(a_count), 0);

    // streaming through the slot wrap with a resident backlog of four
    a_set(1, 4'hF, 32'h1000, 0, 0); step();
    for (int c = 1; c <= 20; c++) begin
      a_set(1, 4'hF, 32'h1000 + 32'(16 * c), 4, 0); #1;
      chk("wrap_count", 64'(a_count), 4);
      step();
    end
    a_set(0, 4'h0, 32'h0, 4, 0); step();
    a_set(0, 4'h0, 32'h0, 0, 0); #1;
    chk("wrap_drained", 64'(a_count), 0);

    // flush with five resident entries and a competing enqueue
    a_set(1, 4'hF, 32'h2000, 0, 0); step();
    a_set(1, 4'b0001, 32'h2100, 0, 0); step();
    a_set(0, 4'h0, 32'h0, 0, 0); #1;
    chk("pre_flush_count", 64'(a_count), 5);
    chk("pre_flush_ready", 64'(a_ready), 0);
    a_set(1, 4'hF, 32'h3000, 0, 1); #1;
    chk("flush_valid", 64'(a_deq_valid), 0);
    step(); a_set(0, 4'h0, 32'h0, 0, 0); #1;
    chk("flush_count", 64'(a_count), 0);
    chk("flush_ready", 64'(a_ready), 1);
    chk("flush_valid_after", 64'(a_deq_valid), 0);

    // reset mid-operation drops contents and the same-cycle bundle
    a_set(1, 4'hF, 32'h4000, 0, 0); step();
    a_set(1, 4'hF, 32'h4010, 0, 0);
    rst = 1'b1;
    exp_pc_q.delete();
    exp_in_q.delete();
    step();
    rst = 1'b0;
    a_set(0, 4'h0, 32'h0, 0, 0); #1;
    chk("rst_mid_count", 64'(a_count), 0);
    chk("rst_mid_valid", 64'(a_deq_valid), 0);
    chk("rst_mid_ready", 64'(a_ready), 1);

    // instance B: no bypass, two-lane output
    b_set(1, 4'hF, 32'h500, 0); #1;
    chk("b_nobyp_valid", 64'(b_deq_valid), 0);
    step(); b_set(0, 4'h0, 32'h0, 2); #1;
    chk("b_count4", 64'(b_count), 4);
    chk("b_valid2", 64'(b_deq_valid), 2'b11);
    chk("b_pc0", 64'(b_deq_pc[31:0]), 32'h500);
    chk("b_pc1", 64'(b_deq_pc[63:32]), 32'h504);
    chk("b_instr1", 64'(b_deq_instr[63:32]), 64'(instr_of(32'h504)));
    step(); b_set(0, 4'h0, 32'h0, 2); #1;
    chk("b_count2", 64'(b_count), 2);
    chk("b_pc0_second", 64'(b_deq_pc[31:0]), 32'h508);
    step(); b_set(0, 4'h0, 32'h0, 0); #1;
    chk("b_count0", 64'(b_count), 0);
    chk("b_valid0", 64'(b_deq_valid), 0);

    for (int c = 0; c < 4; c++) begin
      b_set(1, 4'hF, 32'h600 + 32'(16 * c), 0); #1;
      chk("b_fill_ready", 64'(b_ready), 1);
      step();
    end
    b_set(0, 4'h0, 32'h0, 0); #1;
    chk("b_full_count", 64'(b_count), 16);
    chk("b_full_ready", 64'(b_ready), 0);
    chk("b_full_valid", 64'(b_deq_valid), 2'b11);
    for (int c = 0; c < 8; c++) begin
      b_set(0, 4'h0, 32'h0, 2); #1;
      chk("b_drain_pc0", 64'(b_deq_pc[31:0]), 32'h600 + 32'(8 * c));
      chk("b_drain_pc1", 64'(b_deq_pc[63:32]), 32'h604 + 32'(8 * c));
      step();
    end
    b_set(1, 4'b0110, 32'h700, 0); #1;
    chk("b_drained", 64'(b_count), 0);
    chk("b_cmp_nobyp", 64'(b_deq_valid), 0);
    step(); b_set(0, 4'h0, 32'h0, 2); #1;
    chk("b_cmp_count", 64'(b_count), 2);
    chk("b_cmp_pc0", 64'(b_deq_pc[31:0]), 32'h704);
    chk("b_cmp_pc1", 64'(b_deq_pc[63:32]), 32'h708);
    step(); b_set(0, 4'h0, 32'h0, 0); #1;
    chk("b_cmp_drained", 64'(b_count), 0);

    step();
    chk("sb_drained", 64'(exp_pc_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
